// File: rtl/univ_reg_sr_pkg.sv
// Package for the universal register: operation encodings shared by the
// register, its interface and anything that drives the op field.
package univ_reg_pkg;

  localparam int unsigned OP_W = 3;

  // All eight codes are used, so the op field is fully decoded.
  typedef enum logic [OP_W-1:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_SHL  = 3'd2,
    OP_SHR  = 3'd3,
    OP_ROL  = 3'd4,
    OP_ROR  = 3'd5,
    OP_INC  = 3'd6,
    OP_DEC  = 3'd7
  } op_t;

endpackage

// File: rtl/univ_reg_sr_if.sv
// Control/data bundle of the universal register.
//   master : the block that drives control/data (clr_n, set_n, en, op, d, sin_l, sin_r)
//            and observes the register outputs (q, sout_l, sout_r, co, zero).
//   slave  : the register itself.
interface univ_reg_sr_if
  import univ_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) ();
  logic             clr_n;
  logic             set_n;
  logic             en;
  op_t              op;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic             co;
  logic             zero;

  modport master (
    output clr_n, set_n, en, op, d, sin_l, sin_r,
    input  q, sout_l, sout_r, co, zero
  );

  modport slave (
    input  clr_n, set_n, en, op, d, sin_l, sin_r,
    output q, sout_l, sout_r, co, zero
  );
endinterface

// File: rtl/univ_reg_sr_dff_sr_cell.sv
// Single-bit storage cell with asynchronous active-low reset to RST_VAL.
//   clk   : clock, active edge chosen by NEG_EDGE (0 rising, 1 falling)
//   rst_n : asynchronous reset, active low
//   d     : next value, taken at the active edge
//   q     : stored value
module dff_sr_cell #(
  parameter logic RST_VAL  = 1'b0,
  parameter bit   NEG_EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic q_q;

  if (NEG_EDGE) begin : g_neg
    // Falling-edge storage with asynchronous reset.
    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_q <= RST_VAL;
      end else begin
        q_q <= d;
      end
    end
  end else begin : g_pos
    // Rising-edge storage with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_q <= RST_VAL;
      end else begin
        q_q <= d;
      end
    end
  end

  assign q = q_q;

endmodule

// File: rtl/univ_reg_sr.sv
// Universal register: WIDTH-bit state with async reset, synchronous clear/set
// and an op-coded next-state path (hold, load, shift, rotate, inc, dec).
//   clk     : clock, active edge chosen by NEG_EDGE
//   reset_n : asynchronous reset, active low (q = RESET_VAL, co = 0)
//   bus     : slave side of univ_reg_sr_if (controls in, q/sout/co/zero out)
module univ_reg_sr
  import univ_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL   = '1,
  parameter bit               NEG_EDGE  = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  univ_reg_sr_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1'b1);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;
  logic             co_d;
  logic             co_q;
  logic [WIDTH-1:0] shl_s;
  logic [WIDTH-1:0] shr_s;
  logic [WIDTH-1:0] rol_s;
  logic [WIDTH-1:0] ror_s;

  // Shift/rotate candidates. Built as shift-then-patch so WIDTH=1 degenerates
  // cleanly: shifts load the serial input, rotates return q unchanged.
  always_comb begin
    shl_s          = q_q << 1;
    shl_s[0]       = bus.sin_l;
    shr_s          = q_q >> 1;
    shr_s[WIDTH-1] = bus.sin_r;
    rol_s          = q_q << 1;
    rol_s[0]       = q_q[WIDTH-1];
    ror_s          = q_q >> 1;
    ror_s[WIDTH-1] = q_q[0];
  end

  // Next-state priority: clear, set, enable, then op decode with wrap detect.
  always_comb begin
    q_d  = q_q;
    co_d = 1'b0;
    if (!bus.clr_n) begin
      q_d = '0;
    end else if (!bus.set_n) begin
      q_d = SET_VAL;
    end else if (!bus.en) begin
      q_d = q_q;
    end else begin
      case (bus.op)
        OP_HOLD: q_d = q_q;
        OP_LOAD: q_d = bus.d;
        OP_SHL:  q_d = shl_s;
        OP_SHR:  q_d = shr_s;
        OP_ROL:  q_d = rol_s;
        OP_ROR:  q_d = ror_s;
        OP_INC: begin
          q_d  = q_q + ONE;
          co_d = &q_q;
        end
        OP_DEC: begin
          q_d  = q_q - ONE;
          co_d = ~|q_q;
        end
        default: q_d = q_q;
      endcase
    end
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    dff_sr_cell #(
      .RST_VAL  (RESET_VAL[i]),
      .NEG_EDGE (NEG_EDGE)
    ) u_cell (
      .clk   (clk),
      .rst_n (reset_n),
      .d     (q_d[i]),
      .q     (q_q[i])
    );
  end

  dff_sr_cell #(
    .RST_VAL  (1'b0),
    .NEG_EDGE (NEG_EDGE)
  ) u_co_cell (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (co_d),
    .q     (co_q)
  );

  assign bus.q      = q_q;
  assign bus.co     = co_q;
  assign bus.sout_l = q_q[WIDTH-1];
  assign bus.sout_r = q_q[0];
  assign bus.zero   = (q_q == '0);

endmodule

// File: tb/tb_univ_reg_sr.sv
module tb_univ_reg_sr;
  import univ_reg_pkg::*;

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  // Reference state: plain integers.
  int m8;
  bit c8;
  int m1;
  bit c1;

  univ_reg_sr_if #(.WIDTH(8)) bus8 ();
  univ_reg_sr_if #(.WIDTH(1)) bus1 ();

  univ_reg_sr #(.WIDTH(8), .RESET_VAL(8'h00), .SET_VAL(8'hFF), .NEG_EDGE(1'b0)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .bus(bus8.slave));

  univ_reg_sr #(.WIDTH(1), .RESET_VAL(1'b0), .SET_VAL(1'b1), .NEG_EDGE(1'b1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference next state from the arithmetic meaning of each op.
  function automatic void ref_next(input int w, input int m, input bit clr_n, input bit set_n,
                                   input bit en, input int op, input int dv, input bit sl,
                                   input bit sr, output int nm, output bit nco);
    int modv;
    int top;
    modv = 1 << w;
    top  = modv / 2;
    nco  = 1'b0;
    if (!clr_n)      nm = 0;
    else if (!set_n) nm = modv - 1;
    else if (!en)    nm = m;
    else begin
      case (op)
        0: nm = m;
        1: nm = dv % modv;
        2: nm = (m * 2 + int'(sl)) % modv;
        3: nm = m / 2 + int'(sr) * top;
        4: nm = (m * 2) % modv + m / top;
        5: nm = m / 2 + (m % 2) * top;
        6: begin nm = (m + 1) % modv;        nco = (m == modv - 1); end
        7: begin nm = (m + modv - 1) % modv; nco = (m == 0);        end
        default: nm = m;
      endcase
    end
  endfunction

  task automatic chk8(input string tag);
    check_val({tag, ".q"},      bus8.q,      m8);
    check_val({tag, ".co"},     bus8.co,     c8);
    check_val({tag, ".zero"},   bus8.zero,   (m8 == 0));
    check_val({tag, ".sout_l"}, bus8.sout_l, m8 / 128);
    check_val({tag, ".sout_r"}, bus8.sout_r, m8 % 2);
  endtask

  task automatic chk1(input string tag);
    check_val({tag, ".q"},    bus1.q,    m1);
    check_val({tag, ".co"},   bus1.co,   c1);
    check_val({tag, ".zero"}, bus1.zero, (m1 == 0));
  endtask

  // Drive one rising-edge operation on the 8-bit register, then check after the edge.
  task automatic step8(input string tag, input bit clr_n, input bit set_n, input bit en,
                       input int op, input int dv, input bit sl, input bit sr);
    int nm;
    bit nc;
    bus8.clr_n = clr_n; bus8.set_n = set_n; bus8.en = en;
    bus8.op = op_t'(op[2:0]); bus8.d = dv[7:0]; bus8.sin_l = sl; bus8.sin_r = sr;
    ref_next(8, m8, clr_n, set_n, en, op, dv, sl, sr, nm, nc);
    @(posedge clk); #1;
    m8 = nm; c8 = nc;
    chk8(tag);
  endtask

  // Same for the 1-bit falling-edge register.
  task automatic step1(input string tag, input bit clr_n, input bit set_n, input bit en,
                       input int op, input int dv, input bit sl, input bit sr);
    int nm;
    bit nc;
    bus1.clr_n = clr_n; bus1.set_n = set_n; bus1.en = en;
    bus1.op = op_t'(op[2:0]); bus1.d = dv[0]; bus1.sin_l = sl; bus1.sin_r = sr;
    ref_next(1, m1, clr_n, set_n, en, op, dv, sl, sr, nm, nc);
    @(negedge clk); #1;
    m1 = nm; c1 = nc;
    chk1(tag);
  endtask

  initial begin
    reset_n = 1'b0;
    bus8.clr_n = 1'b1; bus8.set_n = 1'b1; bus8.en = 1'b0; bus8.op = OP_HOLD;
    bus8.d = 8'h00; bus8.sin_l = 1'b0; bus8.sin_r = 1'b0;
    bus1.clr_n = 1'b1; bus1.set_n = 1'b1; bus1.en = 1'b0; bus1.op = OP_HOLD;
    bus1.d = 1'b0; bus1.sin_l = 1'b0; bus1.sin_r = 1'b0;
    m8 = 0; c8 = 1'b0; m1 = 0; c1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk8("rst8");
    chk1("rst1");
    reset_n = 1'b1;

    // Async reset clears a pending wrap flag without a clock edge.
    step8("ld_ff", 1'b1, 1'b1, 1'b1, 1, 8'hFF, 1'b0, 1'b0);
    step8("inc_wrap", 1'b1, 1'b1, 1'b1, 6, 0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1 m8 = 0; c8 = 1'b0;
    chk8("async_rst_co");
    @(negedge clk); #1 reset_n = 1'b1;

    // Async reset mid-cycle after LOAD A5.
    step8("ld_a5", 1'b1, 1'b1, 1'b1, 1, 8'hA5, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1 m8 = 0; c8 = 1'b0;
    chk8("async_rst_a5");
    // Reset held across an active edge discards the pending op.
    bus8.en = 1'b1; bus8.op = OP_LOAD; bus8.d = 8'h3C;
    @(posedge clk); #1;
    chk8("rst_hold_edge");
    reset_n = 1'b1;
    m1 = 0; c1 = 1'b0;

    // Shift / rotate sequence.
    step8("ld_81",  1'b1, 1'b1, 1'b1, 1, 8'h81, 1'b0, 1'b0);
    step8("rol",    1'b1, 1'b1, 1'b1, 4, 0, 1'b0, 1'b0);
    step8("ror1",   1'b1, 1'b1, 1'b1, 5, 0, 1'b0, 1'b0);
    step8("ror2",   1'b1, 1'b1, 1'b1, 5, 0, 1'b0, 1'b0);
    check_val("ror2_const", bus8.q, 8'hC0);
    step8("shl",    1'b1, 1'b1, 1'b1, 2, 0, 1'b1, 1'b0);
    check_val("shl_const", bus8.q, 8'h81);
    step8("shr",    1'b1, 1'b1, 1'b1, 3, 0, 1'b1, 1'b0);
    check_val("shr_const", bus8.q, 8'h40);

    // Increment/decrement wrap.
    step8("ld_fe",  1'b1, 1'b1, 1'b1, 1, 8'hFE, 1'b0, 1'b0);
    step8("inc1",   1'b1, 1'b1, 1'b1, 6, 0, 1'b0, 1'b0);
    step8("inc2",   1'b1, 1'b1, 1'b1, 6, 0, 1'b0, 1'b0);
    check_val("inc2_co_const", bus8.co, 1'b1);
    step8("dec1",   1'b1, 1'b1, 1'b1, 7, 0, 1'b0, 1'b0);
    check_val("dec1_q_const", bus8.q, 8'hFF);
    step8("dec2",   1'b1, 1'b1, 1'b1, 7, 0, 1'b0, 1'b0);
    check_val("dec2_q_const", bus8.q, 8'hFE);

    // Clear beats set; then set alone; clear kills co.
    step8("clr_set", 1'b0, 1'b0, 1'b1, 1, 8'h3C, 1'b0, 1'b0);
    step8("set_only", 1'b1, 1'b0, 1'b1, 1, 8'h3C, 1'b0, 1'b0);
    step8("inc_wrap2", 1'b1, 1'b1, 1'b1, 6, 0, 1'b0, 1'b0);
    step8("clr_co",  1'b0, 1'b1, 1'b1, 7, 0, 1'b0, 1'b0);

    // Enable low holds despite op=INC.
    step8("ld_96", 1'b1, 1'b1, 1'b1, 1, 8'h96, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step8("en_off", 1'b1, 1'b1, 1'b0, 6, 0, 1'b1, 1'b1);

    // Randomized mix on the 8-bit register.
    for (int i = 0; i < 200; i++) begin
      step8("rnd8", ($urandom_range(0, 15) != 0), ($urandom_range(0, 15) != 0),
            ($urandom_range(0, 7) != 0), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom));
    end

    // Falling-edge 1-bit register: LOAD 1 ignored at rising edge.
    @(negedge clk); #1;
    bus1.clr_n = 1'b1; bus1.set_n = 1'b1; bus1.en = 1'b1; bus1.op = OP_LOAD; bus1.d = 1'b1;
    @(posedge clk); #1;
    chk1("neg_no_pos_update");
    step1("neg_ld1", 1'b1, 1'b1, 1'b1, 1, 1, 1'b0, 1'b0);
    step1("neg_inc", 1'b1, 1'b1, 1'b1, 6, 0, 1'b0, 1'b0);
    check_val("neg_inc_co_const", bus1.co, 1'b1);
    step1("neg_dec", 1'b1, 1'b1, 1'b1, 7, 0, 1'b0, 1'b0);
    step1("neg_shl", 1'b1, 1'b1, 1'b1, 2, 0, 1'b0, 1'b1);
    step1("neg_shr", 1'b1, 1'b1, 1'b1, 3, 0, 1'b0, 1'b1);
    step1("neg_rol", 1'b1, 1'b1, 1'b1, 4, 0, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      step1("rnd1", ($urandom_range(0, 15) != 0), ($urandom_range(0, 15) != 0),
            ($urandom_range(0, 7) != 0), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 1)), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
